// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: sequencer states and the
// bundle of register write/flush controls it drives.
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FP_BUSY  = 2'd1,
        ST_MEM_WAIT = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_exe_write;
        logic exe_mem_write;
        logic if_id_flush;
        logic id_exe_flush;
        logic exe_mem_flush;
        logic mem_wb_flush;
    } hz_ctrl_t;

    // A bubble carries no control at all; reset loads bubbles everywhere.
    localparam hz_ctrl_t CTRL_BUBBLE = '0;
    localparam hz_ctrl_t CTRL_RESET  = '1;

endpackage

// File: rtl/pipeline_hazard_controller_fp_latency_counter.sv
// Countdown for the remaining FP cycles in EXE: load, decrement or hold,
// with a zero flag for the sequencer.
module fp_latency_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Neither load nor decrement means frozen, which covers memory stalls.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the five-stage pipeline: combines memory wait,
// multi-cycle FP, load-use and taken-branch hazards into register controls.
module pipeline_hazard_controller
    import hazard_pkg::*;
#(
    parameter int FP_LATENCY = 4,
    parameter int CNT_W      = $clog2(FP_LATENCY + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    input  logic [4:0] ID_EXE_DstReg,
    input  logic       ID_EXE_MemtoReg,
    input  logic       EXE_floatop,
    input  logic       EXE_MEM_memAccess,
    input  logic       dmem_ready,
    input  logic       branch_taken,
    output logic       dmem_req,
    output logic       PC_write,
    output logic       IF_ID_write,
    output logic       ID_EXE_write,
    output logic       EXE_MEM_write,
    output logic       IF_ID_flush,
    output logic       ID_EXE_flush,
    output logic       EXE_MEM_flush,
    output logic       MEM_WB_flush
);

    localparam bit FP_MULTI  = (FP_LATENCY > 1);
    localparam int FP_RELOAD = FP_MULTI ? (FP_LATENCY - 2) : 0;

    hz_state_e        state_q;
    hz_state_e        state_d;
    logic [CNT_W-1:0] fp_cnt;
    logic             fp_cnt_zero;
    logic             cnt_load;
    logic             cnt_dec;

    logic     mem_stall;
    logic     load_use;
    logic     fp_stall;
    hz_ctrl_t ctrl;

    assign mem_stall = EXE_MEM_memAccess & ~dmem_ready;
    assign load_use  = ID_EXE_MemtoReg & (ID_EXE_DstReg != 5'd0) &
                       ((ID_EXE_DstReg == ID_rs) | (ID_EXE_DstReg == ID_rt));
    // The first FP cycle stalls from IDLE; FP_BUSY covers the rest.
    assign fp_stall  = ((state_q == ST_IDLE) & EXE_floatop & FP_MULTI) |
                       ((state_q == ST_FP_BUSY) & ~fp_cnt_zero);

    fp_latency_counter #(
        .CNT_W(CNT_W)
    ) u_fp_cnt (
        .clk       (clk),
        .rst       (rst),
        .load_i    (cnt_load),
        .load_val_i(CNT_W'(FP_RELOAD)),
        .dec_i     (cnt_dec),
        .cnt_o     (fp_cnt),
        .zero_o    (fp_cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_stall) begin
                    state_d = ST_MEM_WAIT;
                end else if (fp_stall) begin
                    state_d  = ST_FP_BUSY;
                    cnt_load = 1'b1;
                end
            end
            ST_FP_BUSY: begin
                if (mem_stall) begin
                    state_d = ST_MEM_WAIT;
                end else if (fp_cnt_zero) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                // Resume an FP op that the memory stall interrupted.
                if (dmem_ready) begin
                    state_d = fp_cnt_zero ? ST_IDLE : ST_FP_BUSY;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        ctrl = CTRL_BUBBLE;
        if (rst) begin
            ctrl = CTRL_RESET;
        end else begin
            ctrl.pc_write      = ~(mem_stall | fp_stall | load_use);
            ctrl.if_id_write   = ~(mem_stall | fp_stall | load_use);
            ctrl.id_exe_write  = ~(mem_stall | fp_stall);
            ctrl.exe_mem_write = ~mem_stall;
            ctrl.if_id_flush   = branch_taken & ~(mem_stall | fp_stall | load_use);
            ctrl.id_exe_flush  = load_use & ~(mem_stall | fp_stall);
            ctrl.exe_mem_flush = fp_stall & ~mem_stall;
            ctrl.mem_wb_flush  = mem_stall;
        end
    end

    assign PC_write      = ctrl.pc_write;
    assign IF_ID_write   = ctrl.if_id_write;
    assign ID_EXE_write  = ctrl.id_exe_write;
    assign EXE_MEM_write = ctrl.exe_mem_write;
    assign IF_ID_flush   = ctrl.if_id_flush;
    assign ID_EXE_flush  = ctrl.id_exe_flush;
    assign EXE_MEM_flush = ctrl.exe_mem_flush;
    assign MEM_WB_flush  = ctrl.mem_wb_flush;
    assign dmem_req      = EXE_MEM_memAccess & ~rst;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench: directed hazard scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_pipeline_hazard_controller;

    localparam int FP_LAT = 4;

    logic       clk;
    logic       rst;
    logic [4:0] ID_rs;
    logic [4:0] ID_rt;
    logic [4:0] ID_EXE_DstReg;
    logic       ID_EXE_MemtoReg;
    logic       EXE_floatop;
    logic       EXE_MEM_memAccess;
    logic       dmem_ready;
    logic       branch_taken;
    logic       dmem_req;
    logic       PC_write;
    logic       IF_ID_write;
    logic       ID_EXE_write;
    logic       EXE_MEM_write;
    logic       IF_ID_flush;
    logic       ID_EXE_flush;
    logic       EXE_MEM_flush;
    logic       MEM_WB_flush;

    int errors = 0;
    int checks = 0;
    bit model_live = 0;
    bit done = 0;

    // Model of the sequencer: fp_left counts FP stall cycles still owed,
    // fp_active says an FP op is being sequenced, waiting marks a memory stall.
    int fp_left = 0;
    bit fp_active = 0;
    bit waiting = 0;

    pipeline_hazard_controller #(
        .FP_LATENCY(FP_LAT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .ID_rs            (ID_rs),
        .ID_rt            (ID_rt),
        .ID_EXE_DstReg    (ID_EXE_DstReg),
        .ID_EXE_MemtoReg  (ID_EXE_MemtoReg),
        .EXE_floatop      (EXE_floatop),
        .EXE_MEM_memAccess(EXE_MEM_memAccess),
        .dmem_ready       (dmem_ready),
        .branch_taken     (branch_taken),
        .dmem_req         (dmem_req),
        .PC_write         (PC_write),
        .IF_ID_write      (IF_ID_write),
        .ID_EXE_write     (ID_EXE_write),
        .EXE_MEM_write    (EXE_MEM_write),
        .IF_ID_flush      (IF_ID_flush),
        .ID_EXE_flush     (ID_EXE_flush),
        .EXE_MEM_flush    (EXE_MEM_flush),
        .MEM_WB_flush     (MEM_WB_flush)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic [8:0] dut_vec();
        return {dmem_req, PC_write, IF_ID_write, ID_EXE_write, EXE_MEM_write,
                IF_ID_flush, ID_EXE_flush, EXE_MEM_flush, MEM_WB_flush};
    endfunction

    function automatic bit m_mem_stall();
        return EXE_MEM_memAccess && !dmem_ready;
    endfunction

    function automatic bit m_fp_stall();
        if (FP_LAT <= 1) return 0;
        if (waiting) return 0;
        if (fp_active) return fp_left > 0;
        return EXE_floatop;
    endfunction

    function automatic logic [8:0] model_vec();
        bit ms, fs, lu, front;
        logic [8:0] v;
        if (rst) return 9'h0FF;
        ms = m_mem_stall();
        fs = m_fp_stall();
        lu = ID_EXE_MemtoReg && ID_EXE_DstReg != 0 &&
             (ID_EXE_DstReg == ID_rs || ID_EXE_DstReg == ID_rt);
        front = ms || fs || lu;
        v[8] = EXE_MEM_memAccess;
        v[7] = !front;
        v[6] = !front;
        v[5] = !(ms || fs);
        v[4] = !ms;
        v[3] = branch_taken && !front;
        v[2] = lu && !(ms || fs);
        v[1] = fs && !ms;
        v[0] = ms;
        return v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            fp_left   <= 0;
            fp_active <= 0;
            waiting   <= 0;
            model_live <= 1;
        end else if (waiting) begin
            if (dmem_ready) begin
                waiting   <= 0;
                fp_active <= fp_left > 0;
            end
        end else if (m_mem_stall()) begin
            waiting <= 1;
        end else if (fp_active) begin
            if (fp_left == 0) fp_active <= 0;
            else fp_left <= fp_left - 1;
        end else if (m_fp_stall()) begin
            fp_active <= 1;
            fp_left   <= FP_LAT - 2;
        end
    end

    always @(negedge clk) begin
        if (model_live && !done) begin
            logic [8:0] exp_v;
            logic [8:0] got_v;
            exp_v = model_vec();
            got_v = dut_vec();
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL model_cycle t=%0t: got %h expected %h", $time, got_v, exp_v);
            end
        end
    end

    task automatic idle_inputs();
        ID_rs = 5'd1; ID_rt = 5'd2; ID_EXE_DstReg = 5'd3; ID_EXE_MemtoReg = 0;
        EXE_floatop = 0; EXE_MEM_memAccess = 0; dmem_ready = 0; branch_taken = 0;
    endtask

    // Inputs are set at posedge+1; outputs are sampled at the following negedge.
    task automatic expect_cycle(input string name, input logic [8:0] exp_v);
        @(negedge clk);
        checks++;
        if (dut_vec() !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, dut_vec(), exp_v);
        end else begin
            $display("ok   %s: %h", name, exp_v);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        idle_inputs();
        @(posedge clk); #1;
        expect_cycle("reset_state", 9'h0FF);
        rst = 0;
        expect_cycle("idle_normal", 9'h0F0);

        ID_EXE_MemtoReg = 1; ID_EXE_DstReg = 5'd8; ID_rs = 5'd8;
        expect_cycle("load_use_stall", 9'h034);
        ID_EXE_MemtoReg = 0;
        expect_cycle("load_use_after", 9'h0F0);
        ID_EXE_MemtoReg = 1; ID_EXE_DstReg = 5'd0; ID_rs = 5'd0;
        expect_cycle("load_use_r0", 9'h0F0);
        idle_inputs();

        EXE_floatop = 1;
        expect_cycle("fp_c1", 9'h012);
        expect_cycle("fp_c2", 9'h012);
        expect_cycle("fp_c3", 9'h012);
        expect_cycle("fp_release", 9'h0F0);
        EXE_floatop = 0;
        expect_cycle("fp_idle", 9'h0F0);

        EXE_MEM_memAccess = 1; dmem_ready = 0;
        expect_cycle("mem_w1", 9'h101);
        expect_cycle("mem_w2", 9'h101);
        expect_cycle("mem_w3", 9'h101);
        dmem_ready = 1;
        expect_cycle("mem_done", 9'h1F0);
        idle_inputs();
        expect_cycle("mem_idle", 9'h0F0);

        EXE_floatop = 1;
        expect_cycle("fpm_c1", 9'h012);
        expect_cycle("fpm_c2", 9'h012);
        EXE_MEM_memAccess = 1; dmem_ready = 0;
        expect_cycle("fpm_w1", 9'h101);
        expect_cycle("fpm_w2", 9'h101);
        dmem_ready = 1;
        expect_cycle("fpm_ready", 9'h1F0);
        EXE_MEM_memAccess = 0; dmem_ready = 0;
        expect_cycle("fpm_resume", 9'h012);
        expect_cycle("fpm_release", 9'h0F0);
        idle_inputs();

        ID_EXE_MemtoReg = 1; ID_EXE_DstReg = 5'd5; ID_rt = 5'd5; branch_taken = 1;
        expect_cycle("lu_branch_stall", 9'h034);
        ID_EXE_MemtoReg = 0;
        expect_cycle("lu_branch_retry", 9'h0F8);
        idle_inputs();

        EXE_MEM_memAccess = 1; dmem_ready = 0;
        expect_cycle("rst_mem_w1", 9'h101);
        rst = 1;
        expect_cycle("rst_mid_wait", 9'h0FF);
        rst = 0; EXE_MEM_memAccess = 0;
        expect_cycle("rst_after", 9'h0F0);
        EXE_floatop = 1;
        expect_cycle("rst_fp_c1", 9'h012);
        expect_cycle("rst_fp_c2", 9'h012);
        expect_cycle("rst_fp_c3", 9'h012);
        expect_cycle("rst_fp_release", 9'h0F0);
        idle_inputs();

        for (int i = 0; i < 600; i++) begin
            rst               = ($urandom_range(0, 39) == 0);
            ID_rs             = 5'($urandom_range(0, 3));
            ID_rt             = 5'($urandom_range(0, 3));
            ID_EXE_DstReg     = 5'($urandom_range(0, 3));
            ID_EXE_MemtoReg   = ($urandom_range(0, 2) == 0);
            EXE_floatop       = ($urandom_range(0, 3) == 0);
            EXE_MEM_memAccess = ($urandom_range(0, 3) == 0);
            dmem_ready        = ($urandom_range(0, 1) == 0);
            branch_taken      = ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
        end

        @(negedge clk);
        done = 1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
